// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - operand-bundle input and encoded-word output stream for instr_encoder
interface instr_encoder_if;
   logic        in_valid;
   logic        in_ready;
   logic [5:0]  op_sel;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [4:0]  shamt;
   logic [15:0] imm;
   logic [25:0] target;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_word;
   logic [31:0] out_addr;

   modport master (
      output in_valid, op_sel, rs, rt, rd, shamt, imm, target, out_ready,
      input  in_ready, out_valid, out_word, out_addr
   );

   modport slave (
      input  in_valid, op_sel, rs, rt, rd, shamt, imm, target, out_ready,
      output in_ready, out_valid, out_word, out_addr
   );
endinterface

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - packs instruction ID + operands into MIPS words streamed with word addresses
// Optional INSTR_ENC_CHECK_EN: op_sel>50 is swallowed without output and sets sticky err_o.
module instr_encoder #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
   parameter int unsigned DEPTH     = 1024,
   localparam int unsigned CW       = $clog2(DEPTH) + 1
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           clear_i,
   instr_encoder_if.slave bus,
   output logic [CW-1:0]  count_o,
   output logic           full_o,
   output logic           err_o
);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic          valid_q, valid_d;
   logic [31:0]   word_q, word_d;
   logic [31:0]   addr_q, addr_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] pending;
   logic [31:0]   enc_word;
   logic [4:0]    f_rs, f_rt, f_rd, f_sh;
   logic [15:0]   f_imm;
   logic          rdy, accept, load, emit, full_next;

   function automatic logic [31:0] r_word(input logic [4:0] a_rs, input logic [4:0] a_rt,
                                          input logic [4:0] a_rd, input logic [4:0] a_sh,
                                          input logic [5:0] fn);
      return {6'b000000, a_rs, a_rt, a_rd, a_sh, fn};
   endfunction

   function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] a_rs,
                                          input logic [4:0] a_rt, input logic [15:0] a_imm);
      return {op, a_rs, a_rt, a_imm};
   endfunction

   assign f_rs  = bus.rs;
   assign f_rt  = bus.rt;
   assign f_rd  = bus.rd;
   assign f_sh  = bus.shamt;
   assign f_imm = bus.imm;

   // Fields an instruction does not use are forced to zero here, not left to the caller.
   always_comb begin
      enc_word = 32'h0000_0000;
      case (bus.op_sel)
         6'd0:    enc_word = i_word(6'h20, f_rs, f_rt, f_imm);
         6'd1:    enc_word = i_word(6'h24, f_rs, f_rt, f_imm);
         6'd2:    enc_word = i_word(6'h21, f_rs, f_rt, f_imm);
         6'd3:    enc_word = i_word(6'h25, f_rs, f_rt, f_imm);
         6'd4:    enc_word = i_word(6'h23, f_rs, f_rt, f_imm);
         6'd5:    enc_word = i_word(6'h28, f_rs, f_rt, f_imm);
         6'd6:    enc_word = i_word(6'h29, f_rs, f_rt, f_imm);
         6'd7:    enc_word = i_word(6'h2B, f_rs, f_rt, f_imm);
         6'd8:    enc_word = r_word(f_rs, f_rt, f_rd, 5'd0, 6'h20);
         6'd9:    enc_word = r_word(f_rs, f_rt, f_rd, 5'd0, 6'h21);
         6'd10:   enc_word = r_word(f_rs, f_rt, f_rd, 5'd0, 6'h22);
         6'd11:   enc_word = r_word(f_rs, f_rt, f_rd, 5'd0, 6'h23);
         6'd12:   enc_word = r_word(5'd0, f_rt, f_rd, f_sh, 6'h00);
         6'd13:   enc_word = r_word(5'd0, f_rt, f_rd, f_sh, 6'h02);
         6'd14:   enc_word = r_word(5'd0, f_rt, f_rd, f_sh, 6'h03);
         6'd15:   enc_word = r_word(f_rs, f_rt, f_rd, 5'd0, 6'h04);
         6'd16:   enc_word = r_word(f_rs, f_rt, f_rd, 5'd0, 6'h06);
         6'd17:   enc_word = r_word(f_rs, f_rt, f_rd, 5'd0, 6'h07);
         6'd18:   enc_word = r_word(f_rs, f_rt, f_rd, 5'd0, 6'h24);
         6'd19:   enc_word = r_word(f_rs, f_rt, f_rd, 5'd0, 6'h25);
         6'd20:   enc_word = r_word(f_rs, f_rt, f_rd, 5'd0, 6'h26);
         6'd21:   enc_word = r_word(f_rs, f_rt, f_rd, 5'd0, 6'h27);
         6'd22:   enc_word = i_word(6'h08, f_rs, f_rt, f_imm);
         6'd23:   enc_word = i_word(6'h09, f_rs, f_rt, f_imm);
         6'd24:   enc_word = i_word(6'h0C, f_rs, f_rt, f_imm);
         6'd25:   enc_word = i_word(6'h0D, f_rs, f_rt, f_imm);
         6'd26:   enc_word = i_word(6'h0E, f_rs, f_rt, f_imm);
         6'd27:   enc_word = i_word(6'h0F, 5'd0, f_rt, f_imm);
         6'd28:   enc_word = r_word(f_rs, f_rt, f_rd, 5'd0, 6'h2A);
         6'd29:   enc_word = i_word(6'h0A, f_rs, f_rt, f_imm);
         6'd30:   enc_word = i_word(6'h0B, f_rs, f_rt, f_imm);
         6'd31:   enc_word = r_word(f_rs, f_rt, f_rd, 5'd0, 6'h2B);
         6'd32:   enc_word = i_word(6'h04, f_rs, f_rt, f_imm);
         6'd33:   enc_word = i_word(6'h05, f_rs, f_rt, f_imm);
         6'd34:   enc_word = i_word(6'h06, f_rs, 5'd0, f_imm);
         6'd35:   enc_word = i_word(6'h07, f_rs, 5'd0, f_imm);
         6'd36:   enc_word = i_word(6'h01, f_rs, 5'd0, f_imm);
         6'd37:   enc_word = i_word(6'h01, f_rs, 5'd1, f_imm);
         6'd38:   enc_word = {6'h02, bus.target};
         6'd39:   enc_word = {6'h03, bus.target};
         6'd40:   enc_word = r_word(f_rs, 5'd0, f_rd, 5'd0, 6'h09);
         6'd41:   enc_word = r_word(f_rs, 5'd0, 5'd0, 5'd0, 6'h08);
         6'd42:   enc_word = r_word(f_rs, f_rt, 5'd0, 5'd0, 6'h18);
         6'd43:   enc_word = r_word(f_rs, f_rt, 5'd0, 5'd0, 6'h19);
         6'd44:   enc_word = r_word(f_rs, f_rt, 5'd0, 5'd0, 6'h1A);
         6'd45:   enc_word = r_word(f_rs, f_rt, 5'd0, 5'd0, 6'h1B);
         6'd46:   enc_word = r_word(5'd0, 5'd0, f_rd, 5'd0, 6'h10);
         6'd47:   enc_word = r_word(5'd0, 5'd0, f_rd, 5'd0, 6'h12);
         6'd48:   enc_word = r_word(f_rs, 5'd0, 5'd0, 5'd0, 6'h11);
         6'd49:   enc_word = r_word(f_rs, 5'd0, 5'd0, 5'd0, 6'h13);
         6'd50:   enc_word = {6'h1C, f_rs, f_rt, 16'h0000};
         default: enc_word = 32'h0000_0000;
      endcase
   end

   // count + pending word never exceeds DEPTH, so equality is the refusal point.
   assign pending   = count_q + CW'(valid_q);
   assign full_next = (pending == DEPTH_C);
   assign emit      = valid_q & bus.out_ready;
   assign rdy       = !full_next & (!valid_q | bus.out_ready);
   assign accept    = bus.in_valid & rdy;

`ifdef INSTR_ENC_CHECK_EN
   logic op_ok;
   logic err_q, err_d;

   assign op_ok = (bus.op_sel <= 6'd50);
   assign load  = accept & op_ok;
   assign err_d = err_q | (accept & !op_ok & !clear_i);
   assign err_o = err_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) err_q <= 1'b0;
      else       err_q <= err_d;
   end
`else
   assign load  = accept;
   assign err_o = 1'b0;
`endif

   always_comb begin
      valid_d = valid_q;
      word_d  = word_q;
      addr_d  = addr_q;
      count_d = count_q;
      if (clear_i) begin
         valid_d = 1'b0;
         addr_d  = BASE_ADDR;
         count_d = '0;
      end else begin
         if (emit) begin
            valid_d = 1'b0;
            addr_d  = addr_q + 32'd4;
            count_d = count_q + CW'(1);
         end
         if (load) begin
            valid_d = 1'b1;
            word_d  = enc_word;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         word_q  <= 32'h0000_0000;
         addr_q  <= BASE_ADDR;
         count_q <= '0;
      end else begin
         valid_q <= valid_d;
         word_q  <= word_d;
         addr_q  <= addr_d;
         count_q <= count_d;
      end
   end

   assign bus.in_ready  = rdy;
   assign bus.out_valid = valid_q;
   assign bus.out_word  = word_q;
   assign bus.out_addr  = addr_q;
   assign count_o       = count_q;
   assign full_o        = (count_q == DEPTH_C);
endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - directed and randomized checks of instr_encoder (default and DEPTH=4 builds)
module tb_instr_encoder;
   localparam int SD = 4;

   logic        clk   = 1'b0;
   logic        rst   = 1'b1;
   logic        clr_a = 1'b0;
   logic        clr_b = 1'b0;
   logic [10:0] cnt_a;
   logic [2:0]  cnt_b;
   logic        full_a, full_b, err_a, err_b;
   int          n_pass = 0;
   int          n_fail = 0;
   int          n_total = 0;

   instr_encoder_if a_if ();
   instr_encoder_if b_if ();

   instr_encoder u_a (
      .clk_i(clk), .rst_i(rst), .clear_i(clr_a), .bus(a_if),
      .count_o(cnt_a), .full_o(full_a), .err_o(err_a)
   );

   instr_encoder #(.DEPTH(SD)) u_b (
      .clk_i(clk), .rst_i(rst), .clear_i(clr_b), .bus(b_if),
      .count_o(cnt_b), .full_o(full_b), .err_o(err_b)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rw(input int rs, input int rt, input int rd, input int sh, input int fn);
      return (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | (32'(sh) << 6) | 32'(fn);
   endfunction

   function automatic logic [31:0] iw(input int op, input int rs, input int rt, input int imm);
      return (32'(op) << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
   endfunction

   // Reference encoder: groups of IDs map to opcode/funct by offset arithmetic.
   function automatic logic [31:0] ref_enc(input int id, input int rs, input int rt, input int rd,
                                           input int sh, input int imm, input int tg);
      int ldst [8] = '{32, 36, 33, 37, 35, 40, 41, 43};
      if (id <= 7)                       return iw(ldst[id], rs, rt, imm);
      if (id >= 8 && id <= 11)           return rw(rs, rt, rd, 0, 32 + id - 8);
      if (id >= 12 && id <= 14)          return rw(0, rt, rd, sh, (id == 12) ? 0 : id - 11);
      if (id >= 15 && id <= 17)          return rw(rs, rt, rd, 0, (id == 15) ? 4 : id - 10);
      if (id >= 18 && id <= 21)          return rw(rs, rt, rd, 0, 36 + id - 18);
      if (id == 22 || id == 23)          return iw(id - 14, rs, rt, imm);
      if (id >= 24 && id <= 26)          return iw(id - 12, rs, rt, imm);
      if (id == 27)                      return iw(15, 0, rt, imm);
      if (id == 28)                      return rw(rs, rt, rd, 0, 42);
      if (id == 29 || id == 30)          return iw(id - 19, rs, rt, imm);
      if (id == 31)                      return rw(rs, rt, rd, 0, 43);
      if (id == 32 || id == 33)          return iw(id - 28, rs, rt, imm);
      if (id == 34 || id == 35)          return iw(id - 28, rs, 0, imm);
      if (id == 36 || id == 37)          return iw(1, rs, id - 36, imm);
      if (id == 38 || id == 39)          return (32'(id - 36) << 26) | 32'(tg);
      if (id == 40)                      return rw(rs, 0, rd, 0, 9);
      if (id == 41)                      return rw(rs, 0, 0, 0, 8);
      if (id >= 42 && id <= 45)          return rw(rs, rt, 0, 0, 24 + id - 42);
      if (id == 46 || id == 47)          return rw(0, 0, rd, 0, 16 + 2 * (id - 46));
      if (id == 48 || id == 49)          return rw(rs, 0, 0, 0, 17 + 2 * (id - 48));
      if (id == 50)                      return iw(28, rs, rt, 0);
      return 32'h0;
   endfunction

   task automatic idle_a();
      a_if.in_valid = 1'b0; a_if.op_sel = '0; a_if.rs = '0; a_if.rt = '0; a_if.rd = '0;
      a_if.shamt = '0; a_if.imm = '0; a_if.target = '0; a_if.out_ready = 1'b1;
   endtask

   task automatic drv_a(input int op, input int rs, input int rt, input int rd,
                        input int sh, input int imm, input int tg);
      a_if.in_valid = 1'b1; a_if.op_sel = 6'(op); a_if.rs = 5'(rs); a_if.rt = 5'(rt);
      a_if.rd = 5'(rd); a_if.shamt = 5'(sh); a_if.imm = 16'(imm); a_if.target = 26'(tg);
   endtask

   task automatic idle_b();
      b_if.in_valid = 1'b0; b_if.op_sel = '0; b_if.rs = '0; b_if.rt = '0; b_if.rd = '0;
      b_if.shamt = '0; b_if.imm = '0; b_if.target = '0; b_if.out_ready = 1'b1;
   endtask

   task automatic drv_b(input int imm);
      b_if.in_valid = 1'b1; b_if.op_sel = 6'd23; b_if.rs = 5'd2; b_if.rt = 5'd3; b_if.imm = 16'(imm);
   endtask

   task automatic pulse_reset();
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
   endtask

   logic [31:0] exp_q[$];
   logic [31:0] bq[$];
   logic [31:0] m_addr;
   int          m_count, n_emit, op, r_rs, r_rt, r_rd, r_sh, r_imm, r_tg;
   logic        exp_rdy, m_err;

   initial begin
      idle_a();
      idle_b();
      @(negedge clk);
      @(negedge clk);
      chk("rst_valid", a_if.out_valid, 0);
      chk("rst_word", a_if.out_word, 0);
      chk("rst_addr", a_if.out_addr, 32'h3000);
      chk("rst_count", cnt_a, 0);
      chk("rst_full", full_a, 0);
      chk("rst_err", err_a, 0);
      rst = 1'b0;

      @(negedge clk); drv_a(25, 0, 1, 0, 0, 16'h1234, 0); #1;
      chk("ori_rdy", a_if.in_ready, 1);
      @(negedge clk); idle_a();
      chk("ori_valid", a_if.out_valid, 1);
      chk("ori_word", a_if.out_word, 32'h3401_1234);
      chk("ori_addr", a_if.out_addr, 32'h3000);
      @(negedge clk);
      chk("ori_drained", a_if.out_valid, 0);
      chk("ori_count", cnt_a, 1);

      pulse_reset();
      @(negedge clk); drv_a(9, 1, 2, 3, 0, 0, 0);
      @(negedge clk); drv_a(12, 7, 1, 2, 4, 0, 0); #1;
      chk("addu_word", a_if.out_word, 32'h0022_1821);
      chk("addu_addr", a_if.out_addr, 32'h3000);
      chk("b2b_rdy", a_if.in_ready, 1);
      @(negedge clk); idle_a();
      chk("sll_valid", a_if.out_valid, 1);
      chk("sll_word", a_if.out_word, 32'h0001_1100);
      chk("sll_addr", a_if.out_addr, 32'h3004);
      @(negedge clk); drv_a(39, 0, 0, 0, 0, 0, 26'h0C00);
      @(negedge clk); idle_a();
      chk("jal_word", a_if.out_word, 32'h0C00_0C00);
      chk("jal_addr", a_if.out_addr, 32'h3008);
      @(negedge clk); drv_a(37, 5, 9, 9, 9, 16'hFFFE, 0);
      @(negedge clk); idle_a();
      chk("bgez_word", a_if.out_word, 32'h04A1_FFFE);
      chk("bgez_addr", a_if.out_addr, 32'h300C);
      @(negedge clk);
      chk("seq_count", cnt_a, 4);

      // Back-pressure: the pending word must hold and be emitted once on release.
      pulse_reset();
      @(negedge clk); drv_a(9, 1, 2, 3, 0, 0, 0); a_if.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); drv_a(10, 4, 5, 6, 0, 0, 0); a_if.out_ready = 1'b0; #1;
         chk("stall_valid", a_if.out_valid, 1);
         chk("stall_word", a_if.out_word, 32'h0022_1821);
         chk("stall_addr", a_if.out_addr, 32'h3000);
         chk("stall_rdy", a_if.in_ready, 0);
      end
      @(negedge clk); idle_a(); #1;
      chk("release_valid", a_if.out_valid, 1);
      @(negedge clk);
      chk("once_valid", a_if.out_valid, 0);
      chk("once_count", cnt_a, 1);

      pulse_reset();
      @(negedge clk); drv_a(63, 1, 2, 3, 4, 16'hAAAA, 0);
      @(negedge clk); idle_a();
`ifdef INSTR_ENC_CHECK_EN
      chk("inv_valid", a_if.out_valid, 0);
      chk("inv_err", err_a, 1);
      chk("inv_addr", a_if.out_addr, 32'h3000);
      @(negedge clk);
      chk("inv_count", cnt_a, 0);
`else
      chk("inv_valid", a_if.out_valid, 1);
      chk("inv_word", a_if.out_word, 32'h0);
      chk("inv_addr", a_if.out_addr, 32'h3000);
      chk("inv_err", err_a, 0);
      @(negedge clk);
      chk("inv_count", cnt_a, 1);
`endif

      @(negedge clk); drv_a(8, 1, 1, 1, 0, 0, 0);
      @(negedge clk); idle_a(); a_if.out_ready = 1'b0;
      rst = 1'b1; #1;
      chk("arst_valid", a_if.out_valid, 0);
      chk("arst_word", a_if.out_word, 0);
      chk("arst_addr", a_if.out_addr, 32'h3000);
      chk("arst_count", cnt_a, 0);
      chk("arst_err", err_a, 0);
      @(negedge clk); rst = 1'b0;

      m_count = 0; m_addr = 32'h3000; m_err = 1'b0; exp_q.delete();
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         op    = ($urandom_range(0, 15) == 0) ? int'($urandom_range(51, 63)) : int'($urandom_range(0, 50));
         r_rs  = int'($urandom_range(0, 31)); r_rt = int'($urandom_range(0, 31));
         r_rd  = int'($urandom_range(0, 31)); r_sh = int'($urandom_range(0, 31));
         r_imm = int'($urandom_range(0, 65535)); r_tg = int'($urandom & 32'h03FF_FFFF);
         drv_a(op, r_rs, r_rt, r_rd, r_sh, r_imm, r_tg);
         a_if.in_valid  = ($urandom_range(0, 3) != 0);
         a_if.out_ready = ($urandom_range(0, 3) != 0);
         #1;
         exp_rdy = (m_count + exp_q.size() < 1024) && (exp_q.size() == 0 || a_if.out_ready);
         chk("rnd_rdy", a_if.in_ready, exp_rdy);
         chk("rnd_valid", a_if.out_valid, exp_q.size() != 0);
         if (exp_q.size() != 0 && a_if.out_ready) begin
            chk("rnd_word", a_if.out_word, exp_q[0]);
            chk("rnd_addr", a_if.out_addr, m_addr);
            void'(exp_q.pop_front());
            m_count++;
            m_addr += 32'd4;
         end
         if (a_if.in_valid && exp_rdy) begin
`ifdef INSTR_ENC_CHECK_EN
            if (op > 50) m_err = 1'b1;
            else exp_q.push_back(ref_enc(op, r_rs, r_rt, r_rd, r_sh, r_imm, r_tg));
`else
            exp_q.push_back(ref_enc(op, r_rs, r_rt, r_rd, r_sh, r_imm, r_tg));
`endif
         end
      end
      @(negedge clk); idle_a();
      chk("rnd_count", cnt_a, m_count);
      chk("rnd_err", err_a, m_err);

      n_emit = 0; bq.delete();
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); drv_b(i + 16'h100); b_if.out_ready = 1'b1; #1;
         exp_rdy = (n_emit + bq.size() < SD) && (bq.size() == 0 || b_if.out_ready);
         chk("d4_rdy", b_if.in_ready, exp_rdy);
         if (b_if.out_valid) begin
            chk("d4_word", b_if.out_word, bq.size() != 0 ? bq[0] : 32'hDEAD_BEEF);
            chk("d4_addr", b_if.out_addr, 32'h3000 + 32'(4 * n_emit));
            if (bq.size() != 0) void'(bq.pop_front());
            n_emit++;
         end
         if (exp_rdy) bq.push_back(ref_enc(23, 2, 3, 0, 0, i + 16'h100, 0));
      end
      @(negedge clk); idle_b(); #1;
      chk("d4_emitted", n_emit, SD);
      chk("d4_full", full_b, 1);
      chk("d4_count", cnt_b, SD);
      chk("d4_rdy_full", b_if.in_ready, 0);
      chk("d4_valid", b_if.out_valid, 0);

      @(negedge clk); clr_b = 1'b1;
      @(negedge clk); clr_b = 1'b0; #1;
      chk("clr_count", cnt_b, 0);
      chk("clr_full", full_b, 0);
      chk("clr_rdy", b_if.in_ready, 1);
      drv_b(16'h55);
      @(negedge clk); idle_b();
      chk("clr_valid", b_if.out_valid, 1);
      chk("clr_addr", b_if.out_addr, 32'h3000);
      chk("clr_word", b_if.out_word, ref_enc(23, 2, 3, 0, 0, 16'h55, 0));
      @(negedge clk);
      chk("clr_count1", cnt_b, 1);

      drv_b(16'h66);
      @(negedge clk); drv_b(16'h77); clr_b = 1'b1;
      @(negedge clk); clr_b = 1'b0; idle_b();
      chk("prio_valid", b_if.out_valid, 0);
      chk("prio_count", cnt_b, 0);
      chk("prio_addr", b_if.out_addr, 32'h3000);
      chk("b_err", err_b, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
